as_uart_gen: RTL and testbench
==============================

Name: as_uart_gen

Overview:
- Parametrised successor of the single-byte UART: full-duplex 8N1-style serial link with configurable data width, bit period and stop bits.
- Valid/ready TX interface and a small RX FIFO, so the core can burst-read received words.
- Sits between the bus-side peripheral wrapper and the board rx/tx pins.

Parameters:
DATA_W, 8, data bits per frame (5..9), sent LSB first
CLKS_PER_BIT, 13020, clk_i cycles per bit (>=8); 125 MHz / 9600 baud
STOP_BITS, 1, stop bits transmitted (1 or 2); RX checks only the first
RX_DEPTH, 4, RX FIFO depth in words (power of two, >=2)

Ports:
clk_i  in  1  system clock, single clock domain
rst_i  in  1  synchronous active-high reset
rx_i  in  1  serial input, asynchronous, idles high
tx_o  out  1  serial output, idles high
tx_data_i  in  DATA_W  word to transmit
tx_valid_i  in  1  TX word offered
tx_ready_o  out  1  transmitter idle, can accept a word
rx_data_o  out  DATA_W  head of RX FIFO
rx_valid_o  out  1  RX FIFO not empty
rx_ready_i  in  1  consumer pops head when rx_valid_o is high
rx_count_o  out  $clog2(RX_DEPTH)+1  words in RX FIFO
frame_err_o  out  1  one-cycle pulse: stop bit sampled low
overrun_o  out  1  one-cycle pulse: word completed while FIFO full
parity_err_o  out  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Reset (rst_i sampled high on a clk_i edge): tx_o=1, tx_ready_o=1, rx_valid_o=0, rx_count_o=0, rx_data_o=0, all error pulses 0. Both FSMs go to IDLE and the FIFO pointers clear.
- Reset mid-frame aborts the frame. tx_o returns high the next cycle and any partial RX word is discarded.
- TX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Handshake: a transfer occurs on a cycle with tx_valid_i && tx_ready_o. tx_data_i is latched and tx_ready_o drops on the next cycle.
  - tx_o goes low on the cycle after acceptance.
  - Each bit is held exactly CLKS_PER_BIT cycles. The STOP state lasts STOP_BITS*CLKS_PER_BIT cycles.
  - tx_ready_o rises on the last STOP cycle + 1. A new word offered then produces back-to-back frames with no extra idle.
  - tx_data_i changes while busy have no effect.
- RX front end: rx_i passes through a 2-flop synchroniser (2-cycle latency).
- RX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE -> START on a synchronised falling edge.
  - START samples at CLKS_PER_BIT/2. If the line is high there, it is a glitch: back to IDLE, no error.
  - Data bits are then sampled every CLKS_PER_BIT cycles at mid-bit and shifted in LSB first.
  - STOP samples mid-bit, then returns to IDLE immediately. This permits resync on the next start edge within half a bit.
- Word disposal at the stop sample:
  - Stop=0: frame_err_o pulses and the word is dropped.
  - Stop=1 and FIFO full: overrun_o pulses and the new word is dropped; FIFO contents are preserved.
  - Otherwise: the word is written, and rx_valid_o/rx_count_o update on the next cycle.
- RX FIFO:
  - rx_data_o always shows the head, first-word fall-through.
  - A pop occurs on rx_valid_o && rx_ready_i. rx_ready_i while empty is ignored.
  - Simultaneous write and pop: count unchanged, both take effect. When full, a simultaneous pop frees space, so the write succeeds and there is no overrun.
  - Pointers wrap modulo RX_DEPTH.
- Error pulses are exactly one clk_i cycle wide and are not sticky.

Optional Feature:
- Macro AS_UART_PARITY_EN.
- Defined: parameter PARITY_ODD (default 0) selects even (0) or odd (1) parity.
  - TX inserts a parity bit (XOR of data, inverted if odd) after the data bits, lasting CLKS_PER_BIT.
  - RX samples the parity bit. On mismatch, parity_err_o pulses at the stop sample and the word is dropped, even if the stop bit is valid. Framing error takes priority over parity error if both occur.
- Undefined: no parity state in either FSM, parity_err_o tied 0, PARITY_ODD absent.

Test Plan:
- Reset: CLKS_PER_BIT=16, hold rst_i 10 cycles -> tx_o=1, tx_ready_o=1, rx_valid_o=0, rx_count_o=0. Assert rst_i mid-TX of 0x55 -> tx_o=1 the next cycle.
- TX 0xA5: offer tx_valid_i=1 -> tx_o low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high. tx_ready_o is back 160 cycles after acceptance. With STOP_BITS=2 it is back after 176.
- Back-to-back TX: 0x01 then 0xFF held valid -> second start bit begins the cycle after the first stop ends, with no idle gap.
- RX 0x69, then a second frame, with rx_ready_i=0 -> rx_valid_o=1, rx_data_o=0x69, rx_count_o=2. Pop twice -> count 0. A 4-cycle low glitch on rx_i -> no word.
- Overrun/framing:
  - Five frames with no pops, RX_DEPTH=4 -> count=4, one overrun_o pulse, head is still the first word.
  - A frame with stop=0 -> frame_err_o pulse and count unchanged.
  - Full FIFO with a pop in the same cycle as a stop sample -> word accepted, no overrun.
- AS_UART_PARITY_EN, PARITY_ODD=0: TX 0x07 -> parity bit 1 on the line. RX 0x03 sent with parity bit 1 -> parity_err_o pulse, word dropped.

Source files
------------

// File: rtl/as_uart_gen.sv
// Parametrised full-duplex UART: TX via valid/ready (tx_ready_o stalls the producer), RX into a first-word-fall-through FIFO one cycle after the stop sample.
// When the FIFO is full and not popped, a new RX word is dropped with an overrun pulse. AS_UART_PARITY_EN adds a parity bit to both directions.

module as_uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   wr_vld_i,
   input  logic [W-1:0]           wr_dat_i,
   input  logic                   rd_rdy_i,
   output logic                   rd_vld_o,
   output logic [W-1:0]           rd_dat_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_wr, do_rd;

   assign rd_vld_o = (cnt_q != '0);
   assign full_o   = (cnt_q == (AW+1)'(DEPTH));
   assign do_rd    = rd_vld_o && rd_rdy_i;
   // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
   assign do_wr    = wr_vld_i && (!full_o || do_rd);
   assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
   assign count_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (do_wr && !do_rd) begin
         cnt_d = cnt_q + (AW+1)'(1);
      end else if (!do_wr && do_rd) begin
         cnt_d = cnt_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
   end
endmodule

module as_uart_gen #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 13020,
   parameter int STOP_BITS    = 1,
   parameter int RX_DEPTH     = 4
`ifdef AS_UART_PARITY_EN
   ,
   parameter bit PARITY_ODD   = 1'b0
`endif
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      rx_i,
   output logic                      tx_o,
   input  logic [DATA_W-1:0]         tx_data_i,
   input  logic                      tx_valid_i,
   output logic                      tx_ready_o,
   output logic [DATA_W-1:0]         rx_data_o,
   output logic                      rx_valid_o,
   input  logic                      rx_ready_i,
   output logic [$clog2(RX_DEPTH):0] rx_count_o,
   output logic                      frame_err_o,
   output logic                      overrun_o,
   output logic                      parity_err_o
);
   localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W);
`ifdef AS_UART_PARITY_EN
   localparam int TXW = DATA_W + 1;
`else
   localparam int TXW = DATA_W;
`endif
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_MAX   = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef AS_UART_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_e;

   state_e          tx_state_q, tx_state_d;
   logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]   tx_bit_q, tx_bit_d;
   logic [TXW-1:0]  tx_sh_q, tx_sh_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
      end
   end

   // Parity rides above the data in the shift register, so it reaches bit 0 after the last data bit.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      case (tx_state_q)
         ST_IDLE: begin
            tx_cnt_d = '0;
            if (tx_valid_i) begin
               tx_state_d = ST_START;
               tx_bit_d   = '0;
`ifdef AS_UART_PARITY_EN
               tx_sh_d    = {(^tx_data_i) ^ PARITY_ODD, tx_data_i};
`else
               tx_sh_d    = tx_data_i;
`endif
            end
         end
         ST_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               tx_sh_d  = tx_sh_q >> 1;
               tx_bit_d = tx_bit_q + BW'(1);
               if (tx_bit_q == BIT_MAX) begin
`ifdef AS_UART_PARITY_EN
                  tx_state_d = ST_PARITY;
`else
                  tx_state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef AS_UART_PARITY_EN
         ST_PARITY: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (tx_cnt_q == STOP_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = ST_IDLE;
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_o       = 1'b1;
      tx_ready_o = (tx_state_q == ST_IDLE);
      case (tx_state_q)
         ST_START:  tx_o = 1'b0;
         ST_DATA:   tx_o = tx_sh_q[0];
`ifdef AS_UART_PARITY_EN
         ST_PARITY: tx_o = tx_sh_q[0];
`endif
         default:   tx_o = 1'b1;
      endcase
   end

   state_e              rx_state_q, rx_state_d;
   logic [CW-1:0]       rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]       rx_bit_q, rx_bit_d;
   logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
   logic                rx_s1_q, rx_s2_q, rx_prev_q;
   logic                stop_smp, par_bad, word_ok, rx_pop, fifo_full;
   logic                frame_err_q, overrun_q;
`ifdef AS_UART_PARITY_EN
   logic                rx_par_q, rx_par_d, parity_err_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= ST_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_sh_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef AS_UART_PARITY_EN
         rx_par_q     <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_s1_q     <= rx_i;
         rx_s2_q     <= rx_s1_q;
         rx_prev_q   <= rx_s2_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_sh_q     <= rx_sh_d;
         frame_err_q <= stop_smp && !rx_s2_q;
         overrun_q   <= word_ok && fifo_full && !rx_pop;
`ifdef AS_UART_PARITY_EN
         rx_par_q     <= rx_par_d;
         parity_err_q <= stop_smp && rx_s2_q && par_bad;
`endif
      end
   end

   // Counting restarts at the mid-start sample, so every later sample lands mid-bit.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CW'(1);
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      stop_smp   = 1'b0;
`ifdef AS_UART_PARITY_EN
      rx_par_d   = rx_par_q;
`endif
      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) rx_state_d = ST_START;
         end
         ST_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
               rx_bit_d = rx_bit_q + BW'(1);
               if (rx_bit_q == BIT_MAX) begin
`ifdef AS_UART_PARITY_EN
                  rx_state_d = ST_PARITY;
`else
                  rx_state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef AS_UART_PARITY_EN
         ST_PARITY: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_par_d   = rx_s2_q;
               rx_state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               stop_smp   = 1'b1;
               rx_state_d = ST_IDLE;
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
`ifdef AS_UART_PARITY_EN
      par_bad = (^{rx_sh_q, rx_par_q}) ^ PARITY_ODD;
`else
      par_bad = 1'b0;
`endif
      word_ok = stop_smp && rx_s2_q && !par_bad;
      rx_pop  = rx_valid_o && rx_ready_i;
   end

   as_uart_fifo #(
      .W     (DATA_W),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_vld_i (word_ok),
      .wr_dat_i (rx_sh_q),
      .rd_rdy_i (rx_ready_i),
      .rd_vld_o (rx_valid_o),
      .rd_dat_o (rx_data_o),
      .full_o   (fifo_full),
      .count_o  (rx_count_o)
   );

   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;
`ifdef AS_UART_PARITY_EN
   assign parity_err_o = parity_err_q;
`else
   assign parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_as_uart_gen.sv
// Directed bench for as_uart_gen: TX framing/timing, back-to-back TX, RX FIFO, glitch, overrun, framing and parity errors.
module tb_as_uart_gen;
   localparam int CPB = 16;
`ifdef AS_UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FLEN   = FB * CPB;
   localparam int POP_AT = FLEN - 6;

   logic       clk = 1'b0;
   logic       rst, rx, tx, txv, txr, rxv, rxr, fe, ov, pe;
   logic [7:0] txd, rxd;
   logic [2:0] rxc;
   logic       tx2, tx2r, rxv2, fe2, ov2, pe2;
   logic [7:0] rxd2;
   logic [2:0] rxc2;
   int         n_vec = 0, n_bad = 0;
   int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
`ifdef AS_UART_PARITY_EN
   logic       par_flip = 1'b0;
`endif

   always #5 clk = ~clk;

   as_uart_gen #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .RX_DEPTH(4)) u_dut (
      .clk_i(clk), .rst_i(rst), .rx_i(rx), .tx_o(tx), .tx_data_i(txd), .tx_valid_i(txv),
      .tx_ready_o(txr), .rx_data_o(rxd), .rx_valid_o(rxv), .rx_ready_i(rxr), .rx_count_o(rxc),
      .frame_err_o(fe), .overrun_o(ov), .parity_err_o(pe));

   as_uart_gen #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .RX_DEPTH(4)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .rx_i(rx), .tx_o(tx2), .tx_data_i(txd), .tx_valid_i(txv),
      .tx_ready_o(tx2r), .rx_data_o(rxd2), .rx_valid_o(rxv2), .rx_ready_i(1'b0), .rx_count_o(rxc2),
      .frame_err_o(fe2), .overrun_o(ov2), .parity_err_o(pe2));

   always @(negedge clk) begin
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
      if (pe) pe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One serial frame on rx, starting at the current negedge; rx_ready pulses once at cycle pop_at.
   task automatic send_rx(input logic [7:0] d, input logic stop_b, input int pop_at);
      logic [FB-1:0] bits;
`ifdef AS_UART_PARITY_EN
      bits = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
      bits = {stop_b, d, 1'b0};
`endif
      for (int c = 0; c < FLEN; c++) begin
         rx  = bits[c / CPB];
         rxr = (c == pop_at);
         @(negedge clk);
      end
      rx  = 1'b1;
      rxr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] drain [4];
      rst = 1'b1; rx = 1'b1; txv = 1'b0; txd = 8'h00; rxr = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_tx_rdy", txr, 1);
      check("rst_rx_vld", rxv, 0);
      check("rst_rx_cnt", rxc, 0);
      check("rst_rx_dat", rxd, 0);
      check("rst_errs", {fe, ov, pe}, 0);
      rst = 1'b0;
      @(negedge clk);

      pat = 8'hA5;
      txd = pat; txv = 1'b1;
      @(negedge clk);
      txv = 1'b0; txd = 8'h00;
      for (int k = 0; k <= FLEN + CPB; k++) begin
         if (k == 0) check("tx_rdy_drop", txr, 0);
         if (k == CPB - 1) check("tx_start_end", tx, 0);
         if (k == CPB) check("tx_bit0_edge", tx, 1);
         if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2)
            check($sformatf("tx_a5_bit%0d", k / CPB - 1), tx, pat[k / CPB - 1]);
`ifdef AS_UART_PARITY_EN
         if (k == 9 * CPB + CPB / 2) check("tx_a5_par", tx, 0);
`endif
         if (k == FLEN - CPB / 2) check("tx_stop", tx, 1);
         if (k == FLEN - 1) check("tx_rdy_busy", txr, 0);
         if (k == FLEN) check("tx_rdy_back", txr, 1);
         if (k == FLEN + CPB / 2) check("tx2_stop2", tx2, 1);
         if (k == FLEN + CPB - 1) check("tx2_rdy_busy", tx2r, 0);
         if (k == FLEN + CPB) check("tx2_rdy_back", tx2r, 1);
         @(negedge clk);
      end

      txd = 8'h01; txv = 1'b1;
      @(negedge clk);
      txd = 8'hFF;
      for (int k = 0; k <= FLEN + CPB + 1; k++) begin
         if (k == 9 * CPB - 1) check("b2b_bit7", tx, 0);
         if (k == FLEN - 1) check("b2b_stop", tx, 1);
         if (k == FLEN) check("b2b_rdy", txr, 1);
         if (k == FLEN + 1) begin
            check("b2b_start2", tx, 0);
            txv = 1'b0;
         end
         if (k == FLEN + CPB) check("b2b_start2_end", tx, 0);
         if (k == FLEN + CPB + 1) check("b2b_ff_bit0", tx, 1);
         @(negedge clk);
      end
      repeat (FLEN + CPB) @(negedge clk);

      txd = 8'h55; txv = 1'b1;
      @(negedge clk);
      txv = 1'b0;
      repeat (40) @(negedge clk);
      check("rst_pre_bit1", tx, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_tx", tx, 1);
      check("rst_mid_rdy", txr, 1);
      rst = 1'b0;
      @(negedge clk);

      send_rx(8'h69, 1'b1, -1);
      send_rx(8'hC3, 1'b1, -1);
      check("rx_vld", rxv, 1);
      check("rx_head", rxd, 8'h69);
      check("rx_cnt2", rxc, 2);
      rxr = 1'b1;
      @(negedge clk);
      rxr = 1'b0;
      check("rx_pop1_dat", rxd, 8'hC3);
      check("rx_pop1_cnt", rxc, 1);
      rxr = 1'b1;
      @(negedge clk);
      check("rx_pop2_cnt", rxc, 0);
      check("rx_pop2_vld", rxv, 0);
      check("rx_empty_dat", rxd, 0);
      @(negedge clk);
      rxr = 1'b0;
      check("rx_empty_pop", rxc, 0);

      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_cnt", rxc, 0);
      check("glitch_fe", fe_cnt, 0);

      for (int i = 1; i <= 5; i++) send_rx(8'(i * 8'h11), 1'b1, -1);
      check("ovr_cnt", rxc, 4);
      check("ovr_pulses", ov_cnt, 1);
      check("ovr_head", rxd, 8'h11);

      send_rx(8'h66, 1'b0, -1);
      check("fe_pulses", fe_cnt, 1);
      check("fe_cnt", rxc, 4);

      send_rx(8'h77, 1'b1, POP_AT);
      check("popfull_cnt", rxc, 4);
      check("popfull_ovr", ov_cnt, 1);
      drain[0] = 8'h22; drain[1] = 8'h33; drain[2] = 8'h44; drain[3] = 8'h77;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain%0d", i), rxd, drain[i]);
         rxr = 1'b1;
         @(negedge clk);
         rxr = 1'b0;
      end
      check("drain_cnt", rxc, 0);

`ifdef AS_UART_PARITY_EN
      txd = 8'h07; txv = 1'b1;
      @(negedge clk);
      txv = 1'b0;
      repeat (9 * CPB + CPB / 2) @(negedge clk);
      check("tx_par07", tx, 1);
      repeat (FLEN) @(negedge clk);
      par_flip = 1'b1;
      send_rx(8'h03, 1'b1, -1);
      par_flip = 1'b0;
      check("par_err_pulse", pe_cnt, 1);
      check("par_err_drop", rxc, 0);
`else
      check("par_err_none", pe_cnt, 0);
`endif
      check("fe_total", fe_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
